mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter sharing the single DataMemory port between the CPU (master 0) and a secondary requester (master 1), such as a program loader or a DMA/debug port.
- Accepts level request/ack handshakes and selects one master per transaction using round-robin.
- Drives the DataMemory address, data, storetype and read/write-enable inputs, and returns read data with a one-cycle ack pulse.
- Sits between CPU/loader and DataMemory in the single-cycle system; DataMemory stays clocked on ~InputClk.

Parameters:
- ADDR_W, 32, address bus width.
- DATA_W, 32, data bus width.
- ST_W, 4, storetype field width (matches ControlBus[10:7]).

Ports:
- InputClk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  master 0 request (level).
- m0_we  in  1  master 0 write (1) / read (0).
- m0_storetype  in  ST_W  master 0 access size/type.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_rdata  out  DATA_W  master 0 read data; valid when m0_ack=1.
- m0_ack  out  1  master 0 transaction done (1-cycle pulse).
- m1_req, m1_we, m1_storetype, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1.
- AddressBus  out  ADDR_W  to DataMemory.
- DataMemoryInput  out  DATA_W  to DataMemory write data.
- DataMemoryOutput  in  DATA_W  from DataMemory read data.
- storetype  out  ST_W  to DataMemory.
- MemReadEn  out  1  to DataMemory.
- MemWriteEn  out  1  to DataMemory.
- grant  out  2  one-hot owner of the transaction in flight; 00 when idle.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; grant=00; both acks=0; both rdata=0.
  - All memory outputs = 0.
  - last_grant=1, so master 0 wins the first tie.
- States: IDLE, ISSUE, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: latch that master's we/storetype/addr/wdata, set grant, go to ISSUE.
  - Both requesting: pick the master != last_grant.
- ISSUE (exactly 1 cycle):
  - Memory outputs are driven from the latched request only; requester changes mid-transaction have no effect.
  - MemReadEn = ~we and MemWriteEn = we.
  - DataMemory samples on the falling edge inside this cycle.
  - At the closing rising edge: capture DataMemoryOutput into the granted rdata (reads only; writes leave rdata unchanged). Set last_grant, go to ACK.
- ACK (exactly 1 cycle):
  - Granted master's ack=1; all memory outputs = 0; grant still shows the owner.
  - Re-arbitration happens here. The just-acked master's req is ignored this cycle.
  - If the other master requests: latch it and go to ISSUE. Otherwise go to IDLE.
- Latency:
  - req rising in IDLE at cycle N: ISSUE at N+1, ack at N+2.
  - Peak throughput: one transaction per 2 cycles.
  - Back-to-back requests from the same master with no contention: 3 cycles each (ACK→IDLE→ISSUE).
- Handshake rules:
  - A requester holds req and its fields stable until ack.
  - req still high on the cycle after ack counts as a new transaction.
  - Dropping req before ack is illegal; the transaction completes anyway.
- Starvation: round-robin guarantees each waiting master is granted within 1 transaction of the other.
- Reset mid-transaction:
  - Immediate return to IDLE; no ack issued.
  - A write already sampled by DataMemory in ISSUE stays committed.
- Simultaneous new requests from both masters in IDLE resolve by last_grant; rdata of the non-granted master is unchanged.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Enabled:
  - Adds inputs m0_lock and m1_lock (1 bit each) and parameter LOCK_MAX (default 8).
  - In ACK, if the acked master has lock=1 and req=1, and its consecutive-grant count < LOCK_MAX: it is re-granted directly (ACK→ISSUE). This overrides round-robin and the ignore-own-req rule.
  - The count resets whenever grant changes or the state passes through IDLE.
  - At LOCK_MAX, normal round-robin applies for that arbitration.
- Disabled: lock ports and counter are absent; pure round-robin as above.

Test Plan:
- Reset then single m0 read, addr 0x10 (memory preloaded 0xDEADBEEF) -> MemReadEn=1 in ISSUE only; m0_ack at cycle 2 after req; m0_rdata=0xDEADBEEF; grant 01→00.
- m1 write addr 0x20, data 0x12345678, storetype word; then m0 read of 0x20 -> MemWriteEn=1 for exactly 1 cycle; m0_rdata=0x12345678.
- Both req asserted in the same cycle after reset, held for 4 transactions -> grant order m0,m1,m0,m1; each transaction spaced 2 cycles; no ack overlap.
- rst asserted during ISSUE of an m1 read -> next cycle: state IDLE, m1_ack never pulses, all memory outputs 0, grant=00.
- m0 alone, req held high continuously -> ack every 3 cycles; m1_ack stays 0; m1_rdata unchanged.
- MEM_ARB_LOCK_EN: m0_lock=1, both masters requesting -> 8 consecutive m0 grants, then m1 granted; with macro off -> strict alternation.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the DataMemory port.
// MEM_ARB_LOCK_EN adds the per-master lock inputs.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ST_W   = 4
);
    logic              m0_req;
    logic              m0_we;
    logic [ST_W-1:0]   m0_storetype;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;

    logic              m1_req;
    logic              m1_we;
    logic [ST_W-1:0]   m1_storetype;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;

`ifdef MEM_ARB_LOCK_EN
    logic              m0_lock;
    logic              m1_lock;
`endif

    logic [ADDR_W-1:0] AddressBus;
    logic [DATA_W-1:0] DataMemoryInput;
    logic [DATA_W-1:0] DataMemoryOutput;
    logic [ST_W-1:0]   storetype;
    logic              MemReadEn;
    logic              MemWriteEn;
    logic [1:0]        grant;

    // Arbiter side.
    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  m0_lock, m1_lock,
`endif
        input  m0_req, m0_we, m0_storetype, m0_addr, m0_wdata,
        output m0_rdata, m0_ack,
        input  m1_req, m1_we, m1_storetype, m1_addr, m1_wdata,
        output m1_rdata, m1_ack,
        output AddressBus, DataMemoryInput, storetype, MemReadEn, MemWriteEn, grant,
        input  DataMemoryOutput
    );

    // Environment side: requesters plus the memory.
    modport master (
`ifdef MEM_ARB_LOCK_EN
        output m0_lock, m1_lock,
`endif
        output m0_req, m0_we, m0_storetype, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack,
        output m1_req, m1_we, m1_storetype, m1_addr, m1_wdata,
        input  m1_rdata, m1_ack,
        input  AddressBus, DataMemoryInput, storetype, MemReadEn, MemWriteEn, grant,
        output DataMemoryOutput
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one DataMemory port between two masters (IDLE -> ISSUE -> ACK).
// Define MEM_ARB_LOCK_EN to add lock inputs allowing up to LOCK_MAX back-to-back re-grants.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ST_W   = 4
`ifdef MEM_ARB_LOCK_EN
    ,
    parameter int unsigned LOCK_MAX = 8
`endif
) (
    input logic              InputClk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StAck} state_e;

    state_e            state_q;
    logic [1:0]        grant_q;
    logic              last_grant_q;  // index of the master served most recently
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ST_W-1:0]   st_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic              m0_ack_q;
    logic              m1_ack_q;

    logic              owner;
    logic              arb_valid;
    logic              arb_sel;
    logic              relock;
    logic              sel_we;
    logic [ST_W-1:0]   sel_st;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign owner = grant_q[1];

`ifdef MEM_ARB_LOCK_EN
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
    logic [CntW-1:0] lock_cnt_q;

    assign relock = (owner ? (bus.m1_lock & bus.m1_req) : (bus.m0_lock & bus.m0_req))
                    && (lock_cnt_q < CntW'(LOCK_MAX));
`else
    assign relock = 1'b0;
`endif

    always_comb begin
        arb_valid = 1'b0;
        arb_sel   = 1'b0;
        case (state_q)
            StIdle: begin
                arb_valid = bus.m0_req | bus.m1_req;
                if (bus.m0_req && bus.m1_req) arb_sel = ~last_grant_q;
                else                          arb_sel = bus.m1_req;
            end
            StAck: begin
                // The master being acked is ignored unless a lock re-grant applies.
                if (relock) begin
                    arb_valid = 1'b1;
                    arb_sel   = owner;
                end else begin
                    arb_valid = owner ? bus.m0_req : bus.m1_req;
                    arb_sel   = ~owner;
                end
            end
            default: ;
        endcase
    end

    assign sel_we    = arb_sel ? bus.m1_we        : bus.m0_we;
    assign sel_st    = arb_sel ? bus.m1_storetype : bus.m0_storetype;
    assign sel_addr  = arb_sel ? bus.m1_addr      : bus.m0_addr;
    assign sel_wdata = arb_sel ? bus.m1_wdata     : bus.m0_wdata;

    always_ff @(posedge InputClk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            st_q         <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
            lock_cnt_q   <= '0;
`endif
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state_q)
                StIssue: begin
                    // DataMemory produced its read data on the falling edge of this cycle.
                    if (rd_en_q) begin
                        if (owner) m1_rdata_q <= bus.DataMemoryOutput;
                        else       m0_rdata_q <= bus.DataMemoryOutput;
                    end
                    last_grant_q <= owner;
                    m0_ack_q     <= ~owner;
                    m1_ack_q     <= owner;
                    addr_q       <= '0;
                    wdata_q      <= '0;
                    st_q         <= '0;
                    rd_en_q      <= 1'b0;
                    wr_en_q      <= 1'b0;
                    state_q      <= StAck;
                end
                default: begin
                    if (arb_valid) begin
                        state_q <= StIssue;
                        grant_q <= arb_sel ? 2'b10 : 2'b01;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        st_q    <= sel_st;
                        rd_en_q <= ~sel_we;
                        wr_en_q <= sel_we;
`ifdef MEM_ARB_LOCK_EN
                        if (state_q == StAck && arb_sel == owner) begin
                            lock_cnt_q <= lock_cnt_q + CntW'(1);
                        end else begin
                            lock_cnt_q <= CntW'(1);
                        end
`endif
                    end else begin
                        state_q <= StIdle;
                        grant_q <= '0;
`ifdef MEM_ARB_LOCK_EN
                        lock_cnt_q <= '0;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.AddressBus      = addr_q;
    assign bus.DataMemoryInput = wdata_q;
    assign bus.storetype       = st_q;
    assign bus.MemReadEn       = rd_en_q;
    assign bus.MemWriteEn      = wr_en_q;
    assign bus.grant           = grant_q;
    assign bus.m0_rdata        = m0_rdata_q;
    assign bus.m1_rdata        = m1_rdata_q;
    assign bus.m0_ack          = m0_ack_q;
    assign bus.m1_ack          = m1_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random two-master traffic,
// each cycle compared against a transaction-slot reference model and a word memory.
module tb_mem_bus_arbiter;

    localparam int LockMax = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();
    mem_bus_arbiter dut (
        .InputClk(clk),
        .rst     (rst),
        .bus     (bus)
    );

    logic        d_req   [2];
    logic        d_we    [2];
    logic [3:0]  d_st    [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];

    assign bus.m0_req       = d_req[0];
    assign bus.m0_we        = d_we[0];
    assign bus.m0_storetype = d_st[0];
    assign bus.m0_addr      = d_addr[0];
    assign bus.m0_wdata     = d_wdata[0];
    assign bus.m1_req       = d_req[1];
    assign bus.m1_we        = d_we[1];
    assign bus.m1_storetype = d_st[1];
    assign bus.m1_addr      = d_addr[1];
    assign bus.m1_wdata     = d_wdata[1];

`ifdef MEM_ARB_LOCK_EN
    logic d_lock [2];
    assign bus.m0_lock = d_lock[0];
    assign bus.m1_lock = d_lock[1];
`endif

    // Unwritten words read back a fixed pattern; word 4 (addr 0x10) is preloaded.
    function automatic logic [31:0] preload(input logic [7:0] idx);
        return (idx == 8'd4) ? 32'hDEADBEEF : {24'hC0FFEE, idx};
    endfunction

    // DataMemory stand-in, clocked on the falling edge.
    logic [31:0] tb_mem [256];
    bit          tb_wr  [256];
    always @(negedge clk) begin
        if (bus.MemWriteEn) begin
            tb_mem[bus.AddressBus[9:2]] <= bus.DataMemoryInput;
            tb_wr[bus.AddressBus[9:2]]  <= 1'b1;
        end
        if (bus.MemReadEn) begin
            bus.DataMemoryOutput <= tb_wr[bus.AddressBus[9:2]] ? tb_mem[bus.AddressBus[9:2]]
                                                              : preload(bus.AddressBus[9:2]);
        end
    end

    // Reference model: a transaction occupies the bus for two slots (access, then ack).
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    int          m_left;   // slots left in the current transaction: 2 access, 1 ack, 0 free
    int          m_owner;
    int          m_last;
    int          m_run;    // consecutive grants to the same master
    logic        m_we;
    logic [3:0]  m_st;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata [2];

    int n_checks = 0;
    int n_err    = 0;
    int we_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_start(input int m);
        m_run   = (m_left != 0 && m == m_owner) ? m_run + 1 : 1;
        m_owner = m;
        m_we    = d_we[m];
        m_st    = d_st[m];
        m_addr  = d_addr[m];
        m_wdata = d_wdata[m];
        m_left  = 2;
    endtask

    task automatic model_edge();
        int other;
        bit lock_hit;
        if (rst) begin
            // A write already presented to memory is committed regardless.
            if (m_left == 2 && m_we) begin
                ref_mem[m_addr[9:2]] = m_wdata;
                ref_wr[m_addr[9:2]]  = 1'b1;
            end
            m_left     = 0;
            m_owner    = 0;
            m_last     = 1;
            m_run      = 0;
            m_rdata[0] = '0;
            m_rdata[1] = '0;
            return;
        end
        if (m_left == 2) begin
            if (m_we) begin
                ref_mem[m_addr[9:2]] = m_wdata;
                ref_wr[m_addr[9:2]]  = 1'b1;
            end else begin
                m_rdata[m_owner] = ref_wr[m_addr[9:2]] ? ref_mem[m_addr[9:2]]
                                                       : preload(m_addr[9:2]);
            end
            m_last = m_owner;
            m_left = 1;
        end else if (m_left == 1) begin
            other    = 1 - m_owner;
            lock_hit = 1'b0;
`ifdef MEM_ARB_LOCK_EN
            lock_hit = d_lock[m_owner] && d_req[m_owner] && (m_run < LockMax);
`endif
            if (lock_hit)          model_start(m_owner);
            else if (d_req[other]) model_start(other);
            else begin
                m_left = 0;
                m_run  = 0;
            end
        end else begin
            if (d_req[0] && d_req[1]) model_start(1 - m_last);
            else if (d_req[0])        model_start(0);
            else if (d_req[1])        model_start(1);
        end
    endtask

    task automatic compare();
        bit issue;
        bit ackp;
        issue = (m_left == 2);
        ackp  = (m_left == 1);
        if (bus.MemWriteEn) we_seen++;
        chk("grant", 32'(bus.grant), (m_left == 0) ? 32'd0 : ((m_owner == 1) ? 32'd2 : 32'd1));
        chk("AddressBus", bus.AddressBus, issue ? m_addr : 32'd0);
        chk("DataMemoryInput", bus.DataMemoryInput, issue ? m_wdata : 32'd0);
        chk("storetype", 32'(bus.storetype), issue ? 32'(m_st) : 32'd0);
        chk("MemReadEn", 32'(bus.MemReadEn), 32'(issue && !m_we));
        chk("MemWriteEn", 32'(bus.MemWriteEn), 32'(issue && m_we));
        chk("m0_ack", 32'(bus.m0_ack), 32'(ackp && m_owner == 0));
        chk("m1_ack", 32'(bus.m1_ack), 32'(ackp && m_owner == 1));
        chk("m0_rdata", bus.m0_rdata, m_rdata[0]);
        chk("m1_rdata", bus.m1_rdata, m_rdata[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic set_txn(input int m, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        d_req[m]   = 1'b1;
        d_we[m]    = we;
        d_st[m]    = 4'h2;
        d_addr[m]  = addr;
        d_wdata[m] = wdata;
    endtask

    task automatic rand_txn(input int m);
        set_txn(m, 1'($urandom_range(1)), {22'd0, 8'($urandom), 2'b00}, $urandom);
        d_st[m] = 4'($urandom);
`ifdef MEM_ARB_LOCK_EN
        d_lock[m] = 1'($urandom_range(1));
`endif
    endtask

    task automatic idle_masters();
        for (int i = 0; i < 2; i++) begin
            d_req[i] = 1'b0;
`ifdef MEM_ARB_LOCK_EN
            d_lock[i] = 1'b0;
`endif
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_masters();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int m, input int budget, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            step();
            cycles++;
            seen = (m == 1) ? bus.m1_ack : bus.m0_ack;
        end
        chk("ack_seen", 32'(seen), 32'd1);
    endtask

    // Run with both/one master re-requesting after every ack; record ack owners and times.
    task automatic collect_acks(input int want, input int budget, output int n,
                                output int ord [16], output int at [16], output int m1_cnt);
        n      = 0;
        m1_cnt = 0;
        for (int c = 1; c <= budget && n < want; c++) begin
            step();
            chk("ack_overlap", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
            for (int i = 0; i < 2; i++) begin
                if (((i == 1) ? bus.m1_ack : bus.m0_ack) && n < 16) begin
                    ord[n] = i;
                    at[n]  = c;
                    n++;
                    if (i == 1) m1_cnt++;
                    set_txn(i, 1'b0, {22'd0, 8'($urandom), 2'b00}, 32'd0);
                end
            end
        end
    endtask

    initial begin
        int cyc;
        int n;
        int m1_cnt;
        int ord [16];
        int at  [16];

        for (int i = 0; i < 2; i++) begin
            d_req[i]   = 1'b0;
            d_we[i]    = 1'b0;
            d_st[i]    = '0;
            d_addr[i]  = '0;
            d_wdata[i] = '0;
`ifdef MEM_ARB_LOCK_EN
            d_lock[i] = 1'b0;
`endif
        end
        m_left = 0; m_owner = 0; m_last = 1; m_run = 0;
        m_we = 1'b0; m_st = '0; m_addr = '0; m_wdata = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;

        // Reset state, then a single m0 read of preloaded address 0x10.
        do_reset();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_m0_rdata", bus.m0_rdata, 32'd0);
        set_txn(0, 1'b0, 32'h10, 32'd0);
        wait_ack(0, 6, cyc);
        chk("t1_latency", 32'(cyc), 32'd2);
        chk("t1_rdata", bus.m0_rdata, 32'hDEADBEEF);
        d_req[0] = 1'b0;
        step();
        chk("t1_grant_idle", 32'(bus.grant), 32'd0);

        // m1 word write to 0x20, then m0 reads it back.
        we_seen = 0;
        set_txn(1, 1'b1, 32'h20, 32'h12345678);
        wait_ack(1, 6, cyc);
        d_req[1] = 1'b0;
        step();
        chk("t2_we_cycles", 32'(we_seen), 32'd1);
        set_txn(0, 1'b0, 32'h20, 32'd0);
        wait_ack(0, 6, cyc);
        chk("t2_rdata", bus.m0_rdata, 32'h12345678);
        d_req[0] = 1'b0;
        step();

        // Both masters request together after reset: strict alternation, 2 cycles apart.
        do_reset();
        set_txn(0, 1'b0, 32'h40, 32'd0);
        set_txn(1, 1'b0, 32'h44, 32'd0);
        collect_acks(4, 30, n, ord, at, m1_cnt);
        chk("t3_count", 32'(n), 32'd4);
        chk("t3_first_at", 32'(at[0]), 32'd2);
        for (int k = 0; k < n; k++) chk("t3_order", 32'(ord[k]), 32'(k % 2));
        for (int k = 1; k < n; k++) chk("t3_spacing", 32'(at[k] - at[k-1]), 32'd2);
        idle_masters();
        step();
        step();

        // Reset while an m1 read is in its access cycle.
        set_txn(1, 1'b0, 32'h30, 32'd0);
        step();
        chk("t4_in_issue", 32'(bus.MemReadEn), 32'd1);
        rst      = 1'b1;
        d_req[1] = 1'b0;
        step();
        rst = 1'b0;
        chk("t4_grant", 32'(bus.grant), 32'd0);
        chk("t4_mem_rd", 32'(bus.MemReadEn), 32'd0);
        chk("t4_addr", bus.AddressBus, 32'd0);
        m1_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.m1_ack) m1_cnt++;
            step();
        end
        chk("t4_no_m1_ack", 32'(m1_cnt), 32'd0);

        // m0 alone holding req: one transaction every 3 cycles.
        set_txn(0, 1'b0, 32'h10, 32'd0);
        collect_acks(3, 20, n, ord, at, m1_cnt);
        chk("t5_count", 32'(n), 32'd3);
        chk("t5_first_at", 32'(at[0]), 32'd2);
        for (int k = 1; k < n; k++) chk("t5_spacing", 32'(at[k] - at[k-1]), 32'd3);
        chk("t5_m1_acks", 32'(m1_cnt), 32'd0);
        chk("t5_m1_rdata", bus.m1_rdata, 32'd0);
        idle_masters();
        step();
        step();

`ifdef MEM_ARB_LOCK_EN
        // Locked m0 keeps the bus for LockMax grants before m1 gets its turn.
        do_reset();
        d_lock[0] = 1'b1;
        set_txn(0, 1'b0, 32'h50, 32'd0);
        set_txn(1, 1'b0, 32'h54, 32'd0);
        collect_acks(LockMax + 1, 40, n, ord, at, m1_cnt);
        chk("t6_count", 32'(n), 32'(LockMax + 1));
        for (int k = 0; k < n; k++) chk("t6_order", 32'(ord[k]), (k < LockMax) ? 32'd0 : 32'd1);
        idle_masters();
        step();
        step();
`endif

        // Random traffic from both masters.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (m_left == 1 && m_owner == i) begin
                    if ($urandom_range(1) == 0) d_req[i] = 1'b0;
                    else                        rand_txn(i);
                end else if (!d_req[i] && $urandom_range(9) < 4) begin
                    rand_txn(i);
                end
            end
        end
        idle_masters();
        for (int c = 0; c < 4; c++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
